// File: rtl/noc_input_port.sv
// Router input buffer: FIFO of flits with XY route computed on write.
// Optional sticky error flag err_o is built when NOC_INPORT_ERR_EN is defined.
module noc_input_port #(
    parameter int DEPTH   = 4,
    parameter int X_COORD = 0,
    parameter int Y_COORD = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                data_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic                       pop_req_i,
    output logic [15:0]                q_o,
    output logic [2:0]                 address_route_o,
    output logic                       valid_o,
`ifdef NOC_INPORT_ERR_EN
    output logic                       err_o,
`endif
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [3:0]    X_C      = 4'(X_COORD);
    localparam logic [3:0]    Y_C      = 4'(Y_COORD);

    typedef enum logic [2:0] {
        ROUTE_N    = 3'd0,
        ROUTE_S    = 3'd1,
        ROUTE_E    = 3'd2,
        ROUTE_W    = 3'd3,
        ROUTE_L    = 3'd4,
        ROUTE_NONE = 3'd7
    } route_e;

    typedef struct packed {
        logic [15:0] data;
        route_e      route;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    route_e          in_route;
    logic            full, empty, push, pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign push  = valid_i && !full;
    assign pop   = pop_req_i && !empty;

    // X is resolved before Y, so a flit only turns N/S once its column matches.
    always_comb begin
        in_route = ROUTE_L;
        if (data_i[7:4] > X_C)      in_route = ROUTE_E;
        else if (data_i[7:4] < X_C) in_route = ROUTE_W;
        else if (data_i[3:0] > Y_C) in_route = ROUTE_N;
        else if (data_i[3:0] < Y_C) in_route = ROUTE_S;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the gated head outputs hide stale entries.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{data: data_i, route: in_route};
    end

`ifdef NOC_INPORT_ERR_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_o <= 1'b0;
        else if ((pop_req_i && empty) || (valid_i && full))
            err_o <= 1'b1;
    end
`endif

    assign ready_o         = !full;
    assign valid_o         = !empty;
    assign count_o         = count;
    assign q_o             = empty ? 16'h0000 : mem[rd_ptr].data;
    assign address_route_o = empty ? ROUTE_NONE : mem[rd_ptr].route;

endmodule
